// File: rtl/hmac_job_arbiter.sv
// Round-robin arbiter sharing one hmac_sha256 engine among N_REQ requesters,
// with optional ownership lock for back-to-back jobs and a WAIT-state watchdog.
module hmac_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_lock,
    input  logic [N_REQ*256-1:0] req_key,
    input  logic [N_REQ*512-1:0] req_msg,
    input  logic [N_REQ*32-1:0]  req_len,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [255:0]         rsp_data,
    output logic                 rsp_error,
    output logic [IDX_W-1:0]     owner,
    output logic                 busy,
    output logic                 eng_start,
    output logic [255:0]         eng_key,
    output logic [511:0]         eng_message,
    output logic [31:0]          eng_length,
    input  logic [255:0]         eng_result,
    input  logic                 eng_done,
    input  logic                 eng_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic             lock_held_reg, lock_held_next;
    logic [255:0]     key_reg, key_next;
    logic [511:0]     msg_reg, msg_next;
    logic [31:0]      len_reg, len_next;
    logic [31:0]      cnt_reg, cnt_next;
    logic [255:0]     rsp_data_reg, rsp_data_next;
    logic             rsp_error_reg, rsp_error_next;

    logic [IDX_W-1:0] lock_base;
    logic [IDX_W:0]   pick;
    logic             grant;
    logic [IDX_W-1:0] grant_idx;

    logic [255:0] key_arr [N_REQ];
    logic [511:0] msg_arr [N_REQ];
    logic [31:0]  len_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign key_arr[gi] = req_key[gi*256 +: 256];
            assign msg_arr[gi] = req_msg[gi*512 +: 512];
            assign len_arr[gi] = req_len[gi*32 +: 32];
        end
    endgenerate

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == N_REQ - 1)
            return '0;
        return i + 1'b1;
    endfunction

    // Returns {found, index} of the first set bit at or after base, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [IDX_W-1:0] base);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(base) + k;
            if (j >= N_REQ)
                j = j - N_REQ;
            if (v[j[IDX_W-1:0]])
                res = {1'b1, j[IDX_W-1:0]};
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            lock_held_reg <= 1'b0;
            key_reg       <= '0;
            msg_reg       <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            rsp_data_reg  <= '0;
            rsp_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            lock_held_reg <= lock_held_next;
            key_reg       <= key_next;
            msg_reg       <= msg_next;
            len_reg       <= len_next;
            cnt_reg       <= cnt_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_error_reg <= rsp_error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_ptr_next    = rr_ptr_reg;
        lock_held_next = lock_held_reg;
        key_next       = key_reg;
        msg_next       = msg_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_error_next = rsp_error_reg;
        grant          = 1'b0;
        grant_idx      = owner_reg;
        // A stale lock hands arbitration to the requester after the owner.
        lock_base      = lock_held_reg ? inc_idx(owner_reg) : rr_ptr_reg;
        pick           = rr_pick(req_valid, lock_base);

        case (state_reg)
            IDLE: begin
                if (!eng_busy) begin
                    if (lock_held_reg && req_valid[owner_reg]) begin
                        grant     = 1'b1;
                        grant_idx = owner_reg;
                    end else begin
                        if (lock_held_reg) begin
                            lock_held_next = 1'b0;
                            rr_ptr_next    = lock_base;
                        end
                        if (pick[IDX_W]) begin
                            grant     = 1'b1;
                            grant_idx = pick[IDX_W-1:0];
                        end
                    end
                end
                if (grant) begin
                    owner_next = grant_idx;
                    key_next   = key_arr[grant_idx];
                    msg_next   = msg_arr[grant_idx];
                    len_next   = len_arr[grant_idx];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    rsp_data_next  = eng_result;
                    rsp_error_next = 1'b0;
                    state_next     = RESP;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                    if ((TIMEOUT != 0) && (cnt_next >= TO_LAST)) begin
                        rsp_data_next  = '0;
                        rsp_error_next = 1'b1;
                        state_next     = RESP;
                    end
                end
            end
            RESP: begin
                lock_held_next = req_lock[owner_reg] & ~rsp_error_reg;
                if (!lock_held_next)
                    rr_ptr_next = inc_idx(owner_reg);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready   = (state_reg == ISSUE) ? (ONE_HOT0 << owner_reg) : '0;
    assign rsp_valid   = (state_reg == RESP) ? (ONE_HOT0 << owner_reg) : '0;
    assign eng_start   = (state_reg == ISSUE);
    assign busy        = (state_reg != IDLE);
    assign owner       = owner_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_error   = rsp_error_reg;
    assign eng_key     = key_reg;
    assign eng_message = msg_reg;
    assign eng_length  = len_reg;
endmodule

// File: tb/tb_hmac_job_arbiter.sv
// Directed bench for hmac_job_arbiter with a simple engine model whose result
// is a fixed mix of the key, message and length it was started with.
module tb_hmac_job_arbiter;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 16;

    logic                 clk, rst_n;
    logic [N_REQ-1:0]     req_valid, req_lock;
    logic [N_REQ*256-1:0] req_key;
    logic [N_REQ*512-1:0] req_msg;
    logic [N_REQ*32-1:0]  req_len;
    logic [N_REQ-1:0]     req_ready, rsp_valid;
    logic [255:0]         rsp_data;
    logic                 rsp_error;
    logic [1:0]           owner;
    logic                 busy, eng_start;
    logic [255:0]         eng_key;
    logic [511:0]         eng_message;
    logic [31:0]          eng_length;
    logic [255:0]         eng_result;
    logic                 eng_done, eng_busy;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int eng_lat = 10;

    hmac_job_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_key(req_key), .req_msg(req_msg), .req_len(req_len),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_error(rsp_error),
        .owner(owner), .busy(busy), .eng_start(eng_start),
        .eng_key(eng_key), .eng_message(eng_message), .eng_length(eng_length),
        .eng_result(eng_result), .eng_done(eng_done), .eng_busy(eng_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    function automatic logic [255:0] key_of(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction
    function automatic logic [511:0] msg_of(input int i);
        return {16{32'h5A00_0000 + 32'(i * 17)}};
    endfunction
    function automatic logic [31:0] len_of(input int i);
        return 32'(64 + i * 3);
    endfunction
    function automatic logic [255:0] exp_res(input int i);
        logic [511:0] m;
        m = msg_of(i);
        return key_of(i) ^ m[255:0] ^ {8{len_of(i)}};
    endfunction
    function automatic int onehot_idx(input logic [N_REQ-1:0] v);
        if ($countones(v) != 1) return -2;
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
        return -2;
    endfunction

    // Engine model: latches its latency on start, pulses done after eng_lat cycles.
    initial begin : engine
        int cnt, lat;
        bit run;
        eng_done = 1'b0; eng_busy = 1'b0; eng_result = '0;
        run = 1'b0; cnt = 0; lat = 0;
        forever begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (!rst_n) begin
                run = 1'b0; eng_busy = 1'b0;
            end else if (run) begin
                cnt++;
                if (cnt == lat) begin
                    eng_done = 1'b1;
                    eng_result = eng_key ^ eng_message[255:0] ^ {8{eng_length}};
                end else if (cnt == lat + 1) begin
                    run = 1'b0; eng_busy = 1'b0;
                end
            end else if (eng_start) begin
                run = 1'b1; cnt = 0; lat = eng_lat; eng_busy = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic load_inputs();
        for (int i = 0; i < N_REQ; i++) begin
            req_key[i*256 +: 256] = key_of(i);
            req_msg[i*512 +: 512] = msg_of(i);
            req_len[i*32 +: 32]   = len_of(i);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = '0; req_lock = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_ready(output int who, output int at);
        who = -1; at = -1;
        for (int n = 0; n < 200; n++) begin
            step();
            if (req_ready != '0) begin
                who = onehot_idx(req_ready); at = cyc;
                $display("grant: requester %0d at cycle %0d", who, at);
                return;
            end
        end
    endtask

    task automatic wait_rsp(output int who, output int at);
        who = -1; at = -1;
        for (int n = 0; n < 200; n++) begin
            step();
            if (rsp_valid != '0) begin
                who = onehot_idx(rsp_valid); at = cyc;
                $display("response: requester %0d at cycle %0d err=%0b data=%h", who, at, rsp_error, rsp_data);
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_lock = '0;
        load_inputs();
        repeat (2) step();
        n_checks++; if ({req_ready, rsp_valid} !== '0) $display("FAIL reset_handshake: got %b expected 0", {req_ready, rsp_valid}); else n_pass++;
        n_checks++; if ({busy, eng_start, rsp_error} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, eng_start, rsp_error}); else n_pass++;
        n_checks++; if (owner !== 2'd0) $display("FAIL reset_owner: got %0d expected 0", owner); else n_pass++;
        n_checks++; if ({rsp_data, eng_key, eng_message, eng_length} !== '0) $display("FAIL reset_data: got nonzero expected 0"); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int c0, who, at, rwho, rat;
        apply_reset();
        req_valid = 4'b0001; c0 = cyc;
        wait_ready(who, at);
        n_checks++; if (who !== 0 || at !== c0 + 1) $display("FAIL single_ready: got idx %0d cycle %0d expected idx 0 cycle %0d", who, at, c0 + 1); else n_pass++;
        n_checks++; if (eng_start !== 1'b1) $display("FAIL single_start: got %b expected 1", eng_start); else n_pass++;
        n_checks++; if (eng_key !== key_of(0) || eng_message !== msg_of(0) || eng_length !== len_of(0)) $display("FAIL single_capture: got len %0d expected %0d", eng_length, len_of(0)); else n_pass++;
        req_valid = '0;
        req_key[255:0] = ~key_of(0);
        wait_rsp(rwho, rat);
        n_checks++; if (rwho !== 0 || rat !== at + eng_lat + 1) $display("FAIL single_rsp: got idx %0d cycle %0d expected idx 0 cycle %0d", rwho, rat, at + eng_lat + 1); else n_pass++;
        n_checks++; if (rsp_data !== exp_res(0) || rsp_error !== 1'b0) $display("FAIL single_data: got %h err %b expected %h err 0", rsp_data, rsp_error, exp_res(0)); else n_pass++;
        step();
        n_checks++; if (busy !== 1'b0 || rsp_valid !== '0 || rsp_data !== exp_res(0)) $display("FAIL single_hold: got busy %b data %h expected busy 0 data %h", busy, rsp_data, exp_res(0)); else n_pass++;
        load_inputs();
    endtask

    task automatic test_fairness();
        int who, at, rwho, rat, last_rsp;
        apply_reset();
        req_valid = 4'b1111; last_rsp = -1;
        for (int k = 0; k < 5; k++) begin
            wait_ready(who, at);
            n_checks++; if (who !== k % 4) $display("FAIL fair_grant%0d: got %0d expected %0d", k, who, k % 4); else n_pass++;
            if (k > 0) begin
                n_checks++; if (at - last_rsp !== 2) $display("FAIL fair_gap%0d: got %0d expected 2", k, at - last_rsp); else n_pass++;
            end
            if (k == 4) req_valid = '0;
            wait_rsp(rwho, rat);
            n_checks++; if (rwho !== k % 4 || rsp_data !== exp_res(k % 4)) $display("FAIL fair_rsp%0d: got idx %0d data %h expected idx %0d data %h", k, rwho, rsp_data, k % 4, exp_res(k % 4)); else n_pass++;
            last_rsp = rat;
        end
    endtask

    task automatic test_wrap();
        int who, at, rwho, rat;
        apply_reset();
        req_valid = 4'b1000;
        wait_ready(who, at);
        req_valid = '0;
        wait_rsp(rwho, rat);
        req_valid = 4'b1001;
        wait_ready(who, at);
        n_checks++; if (who !== 0) $display("FAIL wrap_first: got %0d expected 0", who); else n_pass++;
        req_valid = 4'b1000;
        wait_rsp(rwho, rat);
        wait_ready(who, at);
        n_checks++; if (who !== 3) $display("FAIL wrap_second: got %0d expected 3", who); else n_pass++;
        req_valid = '0;
        wait_rsp(rwho, rat);
        n_checks++; if (rwho !== 3 || rsp_data !== exp_res(3)) $display("FAIL wrap_rsp: got idx %0d data %h expected idx 3 data %h", rwho, rsp_data, exp_res(3)); else n_pass++;
    endtask

    task automatic test_lock();
        int seq [6] = '{0, 1, 2, 2, 2, 3};
        int who, at, rwho, rat;
        apply_reset();
        req_valid = 4'b1111; req_lock = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            wait_ready(who, at);
            n_checks++; if (who !== seq[k]) $display("FAIL lock_grant%0d: got %0d expected %0d", k, who, seq[k]); else n_pass++;
            if (k == 4) req_lock = '0;
            if (k == 5) req_valid = '0;
            wait_rsp(rwho, rat);
            n_checks++; if (rwho !== seq[k] || rsp_error !== 1'b0) $display("FAIL lock_rsp%0d: got idx %0d err %b expected idx %0d err 0", k, rwho, rsp_error, seq[k]); else n_pass++;
        end
    endtask

    task automatic test_done_at_limit();
        int who, at, rwho, rat;
        eng_lat = TIMEOUT - 1;
        req_valid = 4'b0100;
        wait_ready(who, at);
        req_valid = '0;
        wait_rsp(rwho, rat);
        n_checks++; if (rwho !== 2 || rat !== at + TIMEOUT) $display("FAIL limit_rsp: got idx %0d cycle %0d expected idx 2 cycle %0d", rwho, rat, at + TIMEOUT); else n_pass++;
        n_checks++; if (rsp_error !== 1'b0 || rsp_data !== exp_res(2)) $display("FAIL limit_data: got err %b data %h expected err 0 data %h", rsp_error, rsp_data, exp_res(2)); else n_pass++;
        eng_lat = 10;
    endtask

    task automatic test_watchdog();
        int who, at, rwho, rat, extra, start_at;
        eng_lat = 40;
        req_valid = 4'b0010;
        wait_ready(who, at);
        req_valid = 4'b0001;
        step();
        eng_lat = 10;
        wait_rsp(rwho, rat);
        n_checks++; if (rwho !== 1 || rat !== at + TIMEOUT) $display("FAIL wdog_rsp: got idx %0d cycle %0d expected idx 1 cycle %0d", rwho, rat, at + TIMEOUT); else n_pass++;
        n_checks++; if (rsp_error !== 1'b1 || rsp_data !== '0) $display("FAIL wdog_error: got err %b data %h expected err 1 data 0", rsp_error, rsp_data); else n_pass++;
        extra = 0; start_at = -1;
        for (int n = 0; n < 80; n++) begin
            step();
            if (rsp_valid != '0) extra++;
            if (eng_start) begin start_at = cyc; break; end
        end
        n_checks++; if (extra !== 0) $display("FAIL wdog_late_done: got %0d responses expected 0", extra); else n_pass++;
        n_checks++; if (start_at !== at + 42 || req_ready !== 4'b0001) $display("FAIL wdog_restart: got cycle %0d ready %b expected cycle %0d ready 0001", start_at, req_ready, at + 42); else n_pass++;
        req_valid = '0;
        wait_rsp(rwho, rat);
        n_checks++; if (rwho !== 0 || rsp_error !== 1'b0 || rsp_data !== exp_res(0)) $display("FAIL wdog_next: got idx %0d err %b expected idx 0 err 0", rwho, rsp_error); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int who, at, rwho, rat, c0;
        apply_reset();
        eng_lat = 5;
        req_lock = 4'b0010; req_valid = 4'b0010;
        wait_ready(who, at);
        wait_rsp(rwho, rat);
        wait_ready(who, at);
        n_checks++; if (who !== 1) $display("FAIL rstw_relock: got %0d expected 1", who); else n_pass++;
        repeat (3) step();
        rst_n = 1'b0;
        #2;
        n_checks++; if ({busy, eng_start, rsp_error, req_ready, rsp_valid} !== '0) $display("FAIL rstw_flags: got %b expected 0", {busy, eng_start, rsp_error, req_ready, rsp_valid}); else n_pass++;
        n_checks++; if (owner !== 2'd0 || rsp_data !== '0 || eng_key !== '0 || eng_length !== '0) $display("FAIL rstw_regs: got owner %0d len %0d expected 0", owner, eng_length); else n_pass++;
        step(); step();
        rst_n = 1'b1; req_lock = '0; req_valid = 4'b0100; c0 = cyc;
        eng_lat = 10;
        wait_ready(who, at);
        n_checks++; if (who !== 2 || at !== c0 + 1) $display("FAIL rstw_grant: got idx %0d cycle %0d expected idx 2 cycle %0d", who, at, c0 + 1); else n_pass++;
        req_valid = '0;
        wait_rsp(rwho, rat);
        n_checks++; if (rwho !== 2 || rsp_data !== exp_res(2)) $display("FAIL rstw_rsp: got idx %0d data %h expected idx 2 data %h", rwho, rsp_data, exp_res(2)); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_lock = '0;
        req_key = '0; req_msg = '0; req_len = '0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_lock();
        test_done_at_limit();
        test_watchdog();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hmac_job_arbiter.md
Name: hmac_job_arbiter

Overview:
- Shares one hmac_sha256 engine among N_REQ requesters, e.g. several pbkdf2_sha256 cores plus a key-wrap unit.
- Arbitrates round-robin and captures the winner's key, message and length.
- Issues a single-cycle engine start, waits for completion, then routes the result back to the winning requester.
- Supports a lock so one requester can run back-to-back HMAC iterations without re-arbitration.
- Includes a watchdog that aborts a hung job with an error response.

Parameters:
N_REQ, 4, number of requesters (2..16)
TIMEOUT, 4096, max cycles in WAIT before abort; 0 disables the watchdog
IDX_W, $clog2(N_REQ), width of the requester index (derived, not overridable)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester job request; held high until req_ready
req_lock  input  N_REQ  keep ownership after the current job completes
req_key  input  N_REQ*256  per-requester HMAC key; slice i = [i*256 +: 256]
req_msg  input  N_REQ*512  per-requester message; slice i = [i*512 +: 512]
req_len  input  N_REQ*32  per-requester message length in bytes
req_ready  output  N_REQ  one-cycle accept pulse to the granted requester
rsp_valid  output  N_REQ  one-cycle result pulse to the granted requester
rsp_data  output  256  result; valid only while any rsp_valid bit is high
rsp_error  output  1  qualifies rsp_valid; 1 = watchdog abort
owner  output  IDX_W  index of the current or last granted requester
busy  output  1  high in every state except IDLE
eng_start  output  1  one-cycle start pulse to the engine
eng_key  output  256  captured key, stable from ISSUE until the job completes
eng_message  output  512  captured message
eng_length  output  32  captured length
eng_result  input  256  engine hmac_out
eng_done  input  1  engine completion pulse
eng_busy  input  1  engine busy

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0; rr_ptr = 0; lock_held = 0; capture registers and timeout counter cleared.
  - Engine shares rst_n, so an in-flight job is dropped without a response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Waits for eng_busy = 0.
  - If lock_held = 1 and req_valid[owner] = 1: grant owner without arbitration.
  - If lock_held = 1 and req_valid[owner] = 0: clear lock_held, set rr_ptr = owner+1 (mod N_REQ), arbitrate the same cycle.
  - Otherwise: grant the first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... with wrap N_REQ-1 -> 0.
  - On grant: register owner, key, message and length; go to ISSUE.
- ISSUE (1 cycle):
  - eng_start = 1 and req_ready[owner] = 1.
  - Clear timeout counter; go to WAIT.
  - eng_done seen in ISSUE is ignored.
- WAIT:
  - On eng_done: capture eng_result into rsp_data, rsp_error = 0; go to RESP.
  - Otherwise the counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no eng_done: rsp_data = 0, rsp_error = 1; go to RESP.
- RESP (1 cycle):
  - rsp_valid[owner] = 1.
  - Sample lock_held = req_lock[owner] & ~rsp_error; a timeout always releases the lock.
  - If not locked, rr_ptr = owner+1 (mod N_REQ).
  - Go to IDLE.
  - A late eng_done after a timeout is ignored; the next grant waits on eng_busy.
- Latency with an idle arbiter and engine:
  - Request seen at cycle 0 -> eng_start and req_ready at cycle 1.
  - eng_done at cycle k -> rsp_valid at cycle k+1.
  - Next grant decided at cycle k+2, so gaps between jobs are 2 cycles of overhead.
- Inputs are sampled only in the grant cycle; the requester may change them after req_ready.
- Withdrawing req_valid before grant is legal; the requester is simply skipped.
- Simultaneous eng_done and the timeout threshold: eng_done wins (no error).
- rsp_valid and req_ready are never high for more than one bit at a time, nor in the same cycle.
- Outputs owner, rsp_data and rsp_error hold their values until the next update.

Test Plan:
- Single request: req_valid = 0001, engine done 80 cycles after start -> req_ready[0] at cycle 1, eng_start at cycle 1, rsp_valid[0] at cycle 82, rsp_data = eng_result, rsp_error = 0.
- Fairness: req_valid = 1111 held continuously from reset -> grant order 0, 1, 2, 3, 0; each rsp_valid matches owner; no back-to-back grants to one index.
- Pointer wrap: after requester 3 completes, req_valid = 1001 -> requester 0 granted, then 3.
- Lock: requester 2 holds req_lock = 1 for 3 jobs while req_valid = 1111 -> three consecutive grants to 2; after req_lock drops, next grant goes to 3.
- Watchdog: TIMEOUT = 16, engine never asserts eng_done -> rsp_valid[owner] with rsp_error = 1 and rsp_data = 0 exactly 16 cycles after eng_start. A later eng_done produces no response. No new eng_start while eng_busy = 1.
- Reset mid-WAIT with a lock held: assert rst_n = 0 -> all outputs 0 immediately. After release, req_valid = 0100 is granted normally from rr_ptr = 0.
